// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_pkg
// Brief    : Shared sample types and saturating-counter helper for the
//            audio stream buffer.
// Revision : 1.0
// ============================================================================
package audio_pkg;

    localparam int AUDIO_DATA_W = 24;

    typedef logic signed [AUDIO_DATA_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

    // Increment that sticks at all-ones for a counter of the given width (<= 63).
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
        logic [63:0] max_v;
        max_v = (64'd1 << width) - 64'd1;
        return (value >= max_v) ? max_v : value + 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stereo_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stereo_fifo
// Brief    : DEPTH-entry FIFO of stereo pairs with asynchronous head read.
// Revision : 1.0
// ============================================================================
module stereo_fifo
    import audio_pkg::*;
#(
    parameter type T     = stereo_t,
    parameter int  DEPTH = 16,
    parameter int  LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  T                 i_wr_data,
    output T                 o_rd_data,
    output logic [LVL_W-1:0] o_level
);

    localparam int c_PTR_W = $clog2(DEPTH);

    T                   r_mem_q [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [LVL_W-1:0]   r_level_q, w_level_d;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        if (i_flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_level_d  = '0;
        end else begin
            if (i_push) w_wr_ptr_d = r_wr_ptr_q + 1'b1;
            if (i_pop)  w_rd_ptr_d = r_rd_ptr_q + 1'b1;
            case ({i_push, i_pop})
                2'b10:   w_level_d = r_level_q + 1'b1;
                2'b01:   w_level_d = r_level_q - 1'b1;
                default: w_level_d = r_level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_level_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_level_q  <= w_level_d;
        end
    end

    // Storage has no reset: contents are only observed once level says so.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem_q[r_wr_ptr_q] <= i_wr_data;
    end

    assign o_rd_data = r_mem_q[r_rd_ptr_q];
    assign o_level   = r_level_q;

endmodule
`default_nettype wire

// File: rtl/audio_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : audio_stream_buffer
// Brief    : Primed stereo FIFO between codec ADC and DAC with attenuation
//            and saturating overrun/underrun counters.
//            Option macro: AUDIO_STREAM_BUFFER_MONO_MIX_EN (outputs (L+R)>>>1).
// Revision : 1.0
// ============================================================================
module audio_stream_buffer
    import audio_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int DEPTH     = 16,
    parameter int PRIME_LVL = 8,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       flush,
    input  logic [4:0]                 atten,
    input  logic                       read_ready,
    input  logic [DATA_W-1:0]          readdata_left,
    input  logic [DATA_W-1:0]          readdata_right,
    input  logic                       write_ready,
    output logic                       read,
    output logic                       write,
    output logic [DATA_W-1:0]          writedata_left,
    output logic [DATA_W-1:0]          writedata_right,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       primed,
    output logic [CNT_W-1:0]           overrun_cnt,
    output logic [CNT_W-1:0]           underrun_cnt
);

    localparam int c_LVL_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic signed [DATA_W-1:0] left;
        logic signed [DATA_W-1:0] right;
    } pair_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    state_t                   r_state_q;
    logic                     r_primed_q;
    pair_t                    w_in, w_head;
    logic [c_LVL_W-1:0]       w_level;
    logic                     w_empty, w_full, w_room;
    logic                     w_push, w_pop, w_overrun, w_underrun;
    logic signed [DATA_W-1:0] w_mix_l, w_mix_r, w_sh_l, w_sh_r;
    logic signed [DATA_W-1:0] r_wd_l_q, w_wd_l_d, r_wd_r_q, w_wd_r_d;
    logic [CNT_W-1:0]         r_ovr_q, w_ovr_d, r_und_q, w_und_d;

    assign w_in    = {readdata_left, readdata_right};
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == c_LVL_W'(DEPTH));

    assign read       = enable & read_ready & ~reset;
    assign write      = enable & r_primed_q & write_ready & ~w_empty & ~reset;
    assign w_pop      = write;
    assign w_room     = ~w_full | w_pop;
    // A pair read during flush is consumed from the codec but neither stored nor counted.
    assign w_push     = read & w_room & ~flush;
    assign w_overrun  = read & ~w_room & ~flush;
    assign w_underrun = enable & r_primed_q & write_ready & w_empty & ~reset;

    stereo_fifo #(
        .T     (pair_t),
        .DEPTH (DEPTH),
        .LVL_W (c_LVL_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (flush),
        .i_wr_data (w_in),
        .o_rd_data (w_head),
        .o_level   (w_level)
    );

`ifdef AUDIO_STREAM_BUFFER_MONO_MIX_EN
    logic signed [DATA_W:0] w_sum;
    logic                   w_unused_sum_lsb;
    assign w_sum            = {w_head.left[DATA_W-1], w_head.left} + {w_head.right[DATA_W-1], w_head.right};
    assign w_mix_l          = w_sum[DATA_W:1];
    assign w_mix_r          = w_sum[DATA_W:1];
    assign w_unused_sum_lsb = w_sum[0];
`else
    assign w_mix_l = w_head.left;
    assign w_mix_r = w_head.right;
`endif

    assign w_sh_l = w_mix_l >>> atten;
    assign w_sh_r = w_mix_r >>> atten;

    // Output follows the head while data exists and freezes on the last value when empty.
    always_comb begin
        w_wd_l_d = r_wd_l_q;
        w_wd_r_d = r_wd_r_q;
        if (!w_empty) begin
            w_wd_l_d = w_sh_l;
            w_wd_r_d = w_sh_r;
        end
    end

    assign writedata_left  = w_empty ? r_wd_l_q : w_sh_l;
    assign writedata_right = w_empty ? r_wd_r_q : w_sh_r;

    always_comb begin
        w_ovr_d = r_ovr_q;
        w_und_d = r_und_q;
        if (w_overrun)  w_ovr_d = CNT_W'(sat_inc(64'(r_ovr_q), CNT_W));
        if (w_underrun) w_und_d = CNT_W'(sat_inc(64'(r_und_q), CNT_W));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_l_q <= '0;
            r_wd_r_q <= '0;
            r_ovr_q  <= '0;
            r_und_q  <= '0;
        end else begin
            r_wd_l_q <= w_wd_l_d;
            r_wd_r_q <= w_wd_r_d;
            r_ovr_q  <= w_ovr_d;
            r_und_q  <= w_und_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= ST_IDLE;
            r_primed_q <= 1'b0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (enable && !flush && (w_level >= c_LVL_W'(PRIME_LVL))) begin
                        r_state_q  <= ST_PLAY;
                        r_primed_q <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (flush || !enable) begin
                        r_state_q  <= ST_IDLE;
                        r_primed_q <= 1'b0;
                    end
                end
                default: begin
                    r_state_q  <= ST_IDLE;
                    r_primed_q <= 1'b0;
                end
            endcase
        end
    end

    assign level        = w_level;
    assign primed       = r_primed_q;
    assign overrun_cnt  = r_ovr_q;
    assign underrun_cnt = r_und_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_stream_buffer
// Brief    : Directed self-checking bench for audio_stream_buffer.
// Revision : 1.0
// ============================================================================
module tb_audio_stream_buffer;

`ifdef AUDIO_STREAM_BUFFER_MONO_MIX_EN
    localparam logic [23:0] c_PRIME_L = 24'h000000;
    localparam logic [23:0] c_PRIME_R = 24'h000000;
    localparam logic [23:0] c_MIX_L   = 24'h000300;
    localparam logic [23:0] c_MIX_R   = 24'h000300;
`else
    localparam logic [23:0] c_PRIME_L = 24'h000100;
    localparam logic [23:0] c_PRIME_R = 24'hFFFF00;
    localparam logic [23:0] c_MIX_L   = 24'h000200;
    localparam logic [23:0] c_MIX_R   = 24'h000400;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  atten = '0;
    logic        read_ready = 1'b0;
    logic        write_ready = 1'b0;
    logic [23:0] readdata_left = '0;
    logic [23:0] readdata_right = '0;
    logic        read, write, primed;
    logic [23:0] writedata_left, writedata_right;
    logic [4:0]  level;
    logic [15:0] overrun_cnt, underrun_cnt;

    int checks = 0;
    int errors = 0;

    audio_stream_buffer #(
        .DATA_W(24), .DEPTH(16), .PRIME_LVL(8), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush), .atten(atten),
        .read_ready(read_ready), .readdata_left(readdata_left), .readdata_right(readdata_right),
        .write_ready(write_ready), .read(read), .write(write),
        .writedata_left(writedata_left), .writedata_right(writedata_right),
        .level(level), .primed(primed), .overrun_cnt(overrun_cnt), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b1; flush = 1'b0; atten = '0;
        read_ready = 1'b0; write_ready = 1'b0;
        readdata_left = '0; readdata_right = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
        readdata_left = l; readdata_right = r; read_ready = 1'b1;
        tick();
        read_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; read_ready = 1'b1; write_ready = 1'b1;
        tick(); #1;
        checks++; if (read !== 1'b0) begin errors++; $display("FAIL rst_read got %b exp 0", read); end
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL rst_write got %b exp 0", write); end
        tick();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
        checks++; if (primed !== 1'b0) begin errors++; $display("FAIL rst_primed got %b exp 0", primed); end
        checks++; if (overrun_cnt !== 16'd0) begin errors++; $display("FAIL rst_ovr got %0d exp 0", overrun_cnt); end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL rst_und got %0d exp 0", underrun_cnt); end
        checks++; if (writedata_left !== 24'd0) begin errors++; $display("FAIL rst_wdl got %h exp 0", writedata_left); end
        checks++; if (writedata_right !== 24'd0) begin errors++; $display("FAIL rst_wdr got %h exp 0", writedata_right); end
        reset = 1'b0; read_ready = 1'b0; write_ready = 1'b0;
    endtask

    task automatic test_prime_and_drain();
        do_reset();
        readdata_left = 24'h000100; readdata_right = 24'hFFFF00; read_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (read !== 1'b1) begin errors++; $display("FAIL prime_read[%0d] got %b exp 1", i, read); end
            tick();
        end
        read_ready = 1'b0;
        checks++; if (level !== 5'd8) begin errors++; $display("FAIL prime_level got %0d exp 8", level); end
        checks++; if (primed !== 1'b0) begin errors++; $display("FAIL prime_early got %b exp 0", primed); end
        tick();
        checks++; if (primed !== 1'b1) begin errors++; $display("FAIL prime_set got %b exp 1", primed); end
        write_ready = 1'b1; #1;
        checks++; if (write !== 1'b1) begin errors++; $display("FAIL prime_write got %b exp 1", write); end
        checks++; if (writedata_left !== c_PRIME_L) begin errors++; $display("FAIL prime_wdl got %h exp %h", writedata_left, c_PRIME_L); end
        checks++; if (writedata_right !== c_PRIME_R) begin errors++; $display("FAIL prime_wdr got %h exp %h", writedata_right, c_PRIME_R); end
        for (int i = 0; i < 8; i++) tick();
        #1;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL drain_level got %0d exp 0", level); end
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL drain_write got %b exp 0", write); end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL drain_und0 got %0d exp 0", underrun_cnt); end
        tick(); tick(); tick();
        checks++; if (underrun_cnt !== 16'd3) begin errors++; $display("FAIL drain_und3 got %0d exp 3", underrun_cnt); end
        checks++; if (primed !== 1'b1) begin errors++; $display("FAIL drain_primed got %b exp 1", primed); end
        checks++; if (writedata_left !== c_PRIME_L) begin errors++; $display("FAIL drain_hold got %h exp %h", writedata_left, c_PRIME_L); end
        write_ready = 1'b0;
    endtask

    task automatic test_overrun();
        do_reset();
        read_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            readdata_left = 24'(i + 1); readdata_right = 24'(i + 1);
            #1;
            checks++; if (read !== 1'b1) begin errors++; $display("FAIL ovr_read[%0d] got %b exp 1", i, read); end
            tick();
        end
        read_ready = 1'b0;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovr_level got %0d exp 16", level); end
        checks++; if (overrun_cnt !== 16'd4) begin errors++; $display("FAIL ovr_cnt got %0d exp 4", overrun_cnt); end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL ovr_und got %0d exp 0", underrun_cnt); end
    endtask

    task automatic test_full_push_pop();
        readdata_left = 24'd100; readdata_right = 24'd100;
        read_ready = 1'b1; write_ready = 1'b1; #1;
        checks++; if (read !== 1'b1) begin errors++; $display("FAIL full_read got %b exp 1", read); end
        checks++; if (write !== 1'b1) begin errors++; $display("FAIL full_write got %b exp 1", write); end
        checks++; if (writedata_left !== 24'd1) begin errors++; $display("FAIL full_head0 got %h exp 1", writedata_left); end
        tick();
        read_ready = 1'b0; write_ready = 1'b0;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level got %0d exp 16", level); end
        checks++; if (overrun_cnt !== 16'd4) begin errors++; $display("FAIL full_ovr got %0d exp 4", overrun_cnt); end
        checks++; if (writedata_left !== 24'd2) begin errors++; $display("FAIL full_head1 got %h exp 2", writedata_left); end
    endtask

    task automatic test_atten();
        do_reset();
        push_pair(24'hFFF000, 24'hFFF000);
        atten = 5'd4; #1;
        checks++; if (writedata_left !== 24'hFFFF00) begin errors++; $display("FAIL att4_l got %h exp FFFF00", writedata_left); end
        checks++; if (writedata_right !== 24'hFFFF00) begin errors++; $display("FAIL att4_r got %h exp FFFF00", writedata_right); end
        do_reset();
        push_pair(24'h7FFFFF, 24'h7FFFFF);
        atten = 5'd31; #1;
        checks++; if (writedata_left !== 24'h000000) begin errors++; $display("FAIL att31_pos got %h exp 000000", writedata_left); end
        do_reset();
        push_pair(24'h800000, 24'h800000);
        atten = 5'd31; #1;
        checks++; if (writedata_left !== 24'hFFFFFF) begin errors++; $display("FAIL att31_neg got %h exp FFFFFF", writedata_left); end
        atten = 5'd0; #1;
        checks++; if (writedata_left !== 24'h800000) begin errors++; $display("FAIL att0_neg got %h exp 800000", writedata_left); end
    endtask

    task automatic test_flush();
        do_reset();
        read_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            readdata_left = 24'(i); readdata_right = 24'(i);
            tick();
        end
        read_ready = 1'b0; write_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        write_ready = 1'b0;
        checks++; if (level !== 5'd10) begin errors++; $display("FAIL flush_pre_level got %0d exp 10", level); end
        checks++; if (primed !== 1'b1) begin errors++; $display("FAIL flush_pre_primed got %b exp 1", primed); end
        flush = 1'b1; read_ready = 1'b1;
        tick();
        flush = 1'b0; read_ready = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_level got %0d exp 0", level); end
        checks++; if (primed !== 1'b0) begin errors++; $display("FAIL flush_primed got %b exp 0", primed); end
        checks++; if (overrun_cnt !== 16'd2) begin errors++; $display("FAIL flush_ovr got %0d exp 2", overrun_cnt); end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL flush_und got %0d exp 0", underrun_cnt); end
    endtask

    task automatic test_enable_low();
        do_reset();
        for (int i = 0; i < 9; i++) push_pair(24'(i), 24'(i));
        tick();
        checks++; if (primed !== 1'b1) begin errors++; $display("FAIL en_primed_pre got %b exp 1", primed); end
        enable = 1'b0; read_ready = 1'b1; write_ready = 1'b1; #1;
        checks++; if (read !== 1'b0) begin errors++; $display("FAIL en_read got %b exp 0", read); end
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL en_write got %b exp 0", write); end
        tick();
        read_ready = 1'b0; write_ready = 1'b0;
        checks++; if (primed !== 1'b0) begin errors++; $display("FAIL en_primed got %b exp 0", primed); end
        checks++; if (level !== 5'd9) begin errors++; $display("FAIL en_level got %0d exp 9", level); end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL en_und got %0d exp 0", underrun_cnt); end
        enable = 1'b1;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 3; i++) push_pair(24'h000055, 24'h000055);
        read_ready = 1'b1; write_ready = 1'b1; reset = 1'b1; #1;
        checks++; if (read !== 1'b0) begin errors++; $display("FAIL mid_read got %b exp 0", read); end
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL mid_write got %b exp 0", write); end
        tick();
        reset = 1'b0; read_ready = 1'b0; write_ready = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", level); end
        checks++; if (writedata_left !== 24'd0) begin errors++; $display("FAIL mid_wdl got %h exp 0", writedata_left); end
    endtask

    task automatic test_mono_mix();
        do_reset();
        push_pair(24'h000200, 24'h000400);
        #1;
        checks++; if (writedata_left !== c_MIX_L) begin errors++; $display("FAIL mix_l got %h exp %h", writedata_left, c_MIX_L); end
        checks++; if (writedata_right !== c_MIX_R) begin errors++; $display("FAIL mix_r got %h exp %h", writedata_right, c_MIX_R); end
    endtask

    initial begin
        test_reset();
        test_prime_and_drain();
        test_overrun();
        test_full_push_pop();
        test_atten();
        test_flush();
        test_enable_low();
        test_reset_midstream();
        test_mono_mix();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/audio_stream_buffer.md
Name: audio_stream_buffer

Overview:
- Parametrised stereo sample buffer between the audio_codec read port (ADC) and write port (DAC).
- Drains ADC samples into a DEPTH-entry FIFO and plays them to the DAC once a priming threshold is reached.
- Applies per-output arithmetic attenuation and keeps saturating overrun/underrun counters.
- Sits in DE1_SoC between the codec instance and the codec's read/write/writedata signals; replaces a direct loopback.

Parameters:
- DATA_W, 24, sample width per channel (two's complement).
- DEPTH, 16, FIFO entries (stereo pairs); power of two, at least 4.
- PRIME_LVL, 8, level that must be reached before playback starts; 1..DEPTH.
- CNT_W, 16, width of the overrun/underrun counters.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high reset
- enable  in  1  when low, no codec handshakes occur
- flush  in  1  synchronous FIFO clear (single-cycle pulse or level)
- atten  in  5  right-shift amount applied to output samples
- read_ready  in  1  codec has an ADC pair available
- readdata_left / readdata_right  in  DATA_W each  ADC samples
- write_ready  in  1  codec can accept a DAC pair
- read  out  1  pop strobe to codec (combinational)
- write  out  1  push strobe to codec (combinational)
- writedata_left / writedata_right  out  DATA_W each  DAC samples
- level  out  $clog2(DEPTH+1)  current FIFO occupancy
- primed  out  1  playback active
- overrun_cnt  out  CNT_W  dropped input pairs, saturating
- underrun_cnt  out  CNT_W  missed output slots, saturating

Behaviour:
- Reset: level=0, primed=0, both counters=0, read=0, write=0, writedata=0, pointers=0. FIFO contents are don't-care.
- read = enable & read_ready & ~reset. Every accepted pair is consumed from the codec, even when the FIFO is full.
- Push occurs when read is high and (level<DEPTH or a pop happens in the same cycle). Otherwise the pair is discarded and overrun_cnt increments (saturating at all-ones).
- write = enable & primed & write_ready & (level>0) & ~reset.
- Pop occurs when write is high.
- Underrun: enable & primed & write_ready & level==0 increments underrun_cnt (saturating). write stays 0 in that cycle.
- Data path: writedata is the FIFO head read asynchronously, passed through an arithmetic right shift by atten.
  - atten >= DATA_W yields 0 for non-negative samples and all-ones (-1) for negative samples.
  - When level==0, writedata holds its previous registered value.
- Latency: a pair pushed into an empty, primed FIFO appears on writedata in the next cycle.
- Level update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged (also valid when full)
  - pointers wrap modulo DEPTH
- Primed state machine, two states:
  - IDLE -> PLAY when level >= PRIME_LVL (evaluated on the registered level).
  - PLAY -> IDLE on flush, on enable low, or on reset.
  - An underrun does not leave PLAY.
- Flush: next cycle level=0, pointers=0, primed=0. Counters are kept. A push in the flush cycle is discarded and not counted.
- enable low: FIFO contents and counters are held; primed clears.
- Reset mid-stream: all state clears in the next cycle; the strobes are combinationally 0 while reset is high.

Optional Feature:
- Macro: AUDIO_STREAM_BUFFER_MONO_MIX_EN.
- Defined: both writedata outputs carry (L+R)>>>1. The sum is computed at DATA_W+1 bits and sign-preserving, then atten is applied.
- Undefined: channels pass independently. Port list is identical in both cases.

Decomposition:
- Package audio_pkg:
  - typedef sample_t (logic signed [DATA_W-1:0])
  - typedef stereo_t (struct of left/right sample_t)
  - constant AUDIO_DATA_W=24
  - function sat_inc for the counters
- One sub-module: stereo_fifo.
  - Holds DEPTH x stereo_t, pointers and level, with push/pop/flush inputs.
  - Provides the asynchronous head read.
- The top module holds the primed FSM, the handshakes, attenuation and counters.

Test Plan:
- Reset, enable=1, atten=0, 8 reads (L=0x000100, R=0xFFFF00) -> primed=1 after the 8th push. The next write_ready gives write=1 and writedata=0x000100/0xFFFF00.
- Hold write_ready=0 and apply 20 reads with DEPTH=16 -> level=16, overrun_cnt=4, and read stays high on all 20 pairs.
- Prime, then drain to empty with write_ready held high -> 1 underrun_cnt increment per empty cycle, primed stays 1, write=0.
- FIFO full and read_ready & write_ready in the same cycle -> push and pop both occur, level stays 16, overrun_cnt unchanged.
- atten=4 with L=0xFFF000 -> 0xFFFF00. atten=31 with L=0x7FFFFF -> 0. atten=31 with L=0x800000 -> 0xFFFFFF.
- flush while level=10 and primed=1 -> next cycle level=0, primed=0, counters unchanged. MONO_MIX build: L=0x000200, R=0x000400 -> both outputs 0x000300.
